// File: rtl/mac_stream_arbiter.sv
// Two-requester AXI-Stream arbiter feeding a MAC: packet-locked round-robin grant,
// with issue throttled by a count of packets whose single result beat has not yet returned.
module mac_stream_arbiter #(
  parameter int unsigned C_DATA_WIDTH      = 8,
  parameter int unsigned C_MAX_OUTSTANDING = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [2*C_DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                      S0_AXIS_TVALID,
  input  logic                      S0_AXIS_TLAST,
  input  logic                      S0_AXIS_TUSER,
  output logic                      S0_AXIS_TREADY,
  input  logic [2*C_DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                      S1_AXIS_TVALID,
  input  logic                      S1_AXIS_TLAST,
  input  logic                      S1_AXIS_TUSER,
  output logic                      S1_AXIS_TREADY,
  output logic [2*C_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TUSER,
  output logic [7:0]                M_AXIS_TID,
  input  logic                      M_AXIS_TREADY,
  input  logic                      R_AXIS_TVALID,
  input  logic                      R_AXIS_TREADY,
  output logic [1:0]                GRANT,
  output logic [3:0]                OUTSTANDING
);

  if (C_MAX_OUTSTANDING < 1 || C_MAX_OUTSTANDING > 15) begin : gen_bad_param
    $error("C_MAX_OUTSTANDING must be in 1..15");
  end

  localparam logic [3:0] MaxOut = 4'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    StIdle,
    StLock0,
    StLock1
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] outstanding_q, outstanding_d;
  logic       below_limit;
  logic       pkt_done;
  logic       result_done;

  assign below_limit = outstanding_q < MaxOut;
  // M_AXIS_TVALID is zero in idle, so this can only fire while a grant is held.
  assign pkt_done    = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
  assign result_done = R_AXIS_TVALID & R_AXIS_TREADY;
  assign OUTSTANDING = outstanding_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      outstanding_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (below_limit) begin
          if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
            state_d = last_grant_q ? StLock0 : StLock1;
          end else if (S0_AXIS_TVALID) begin
            state_d = StLock0;
          end else if (S1_AXIS_TVALID) begin
            state_d = StLock1;
          end
        end
      end
      StLock0: begin
        if (pkt_done) begin
          state_d      = StIdle;
          last_grant_d = 1'b0;
        end
      end
      StLock1: begin
        if (pkt_done) begin
          state_d      = StIdle;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Simultaneous issue and return cancel; a stray return at zero is ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    if (pkt_done && !result_done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (result_done && !pkt_done && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_comb begin
    M_AXIS_TDATA   = '0;
    M_AXIS_TVALID  = 1'b0;
    M_AXIS_TLAST   = 1'b0;
    M_AXIS_TUSER   = 1'b0;
    M_AXIS_TID     = 8'd0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    GRANT          = 2'b00;
    unique case (state_q)
      StLock0: begin
        M_AXIS_TDATA   = S0_AXIS_TDATA;
        M_AXIS_TVALID  = S0_AXIS_TVALID;
        M_AXIS_TLAST   = S0_AXIS_TLAST;
        M_AXIS_TUSER   = S0_AXIS_TUSER;
        M_AXIS_TID     = 8'd0;
        S0_AXIS_TREADY = M_AXIS_TREADY;
        GRANT          = 2'b01;
      end
      StLock1: begin
        M_AXIS_TDATA   = S1_AXIS_TDATA;
        M_AXIS_TVALID  = S1_AXIS_TVALID;
        M_AXIS_TLAST   = S1_AXIS_TLAST;
        M_AXIS_TUSER   = S1_AXIS_TUSER;
        M_AXIS_TID     = 8'd1;
        S1_AXIS_TREADY = M_AXIS_TREADY;
        GRANT          = 2'b10;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mac_stream_arbiter.sv
// Scoreboard bench for mac_stream_arbiter: per-requester beat queues, a packet-level
// grant/outstanding reference, directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_mac_stream_arbiter;
  localparam int unsigned DW   = 8;
  localparam int unsigned TW   = 2 * DW;
  localparam int unsigned MAXO = 4;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [TW-1:0] s_data[2];
  logic          s_valid[2], s_last[2], s_user[2], s_ready[2];
  logic [TW-1:0] M_TDATA;
  logic          M_TVALID, M_TLAST, M_TUSER, M_TREADY;
  logic [7:0]    M_TID;
  logic          r_valid, r_ready;
  logic [1:0]    GRANT;
  logic [3:0]    OUTSTANDING;

  int checks = 0;
  int errors = 0;

  beat_t      send_q[2][$];
  beat_t      exp_q[2][$];
  logic [7:0] tid_log[$];

  bit manual = 0, m_auto = 0, r_auto = 0;
  int m_pct = 100, r_pct = 0, bubble_pct = 0;
  bit acc[2];

  // Reference state kept by the monitor
  int         out_m = 0;
  int         last_g = 1;
  logic [1:0] grant_exp = 2'b00;
  bit         in_pkt = 0, prev_stall = 0, rst_prev = 1;
  logic [31:0] prev_m;

  mac_stream_arbiter #(.C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAXO)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S0_AXIS_TDATA (s_data[0]),
    .S0_AXIS_TVALID(s_valid[0]),
    .S0_AXIS_TLAST (s_last[0]),
    .S0_AXIS_TUSER (s_user[0]),
    .S0_AXIS_TREADY(s_ready[0]),
    .S1_AXIS_TDATA (s_data[1]),
    .S1_AXIS_TVALID(s_valid[1]),
    .S1_AXIS_TLAST (s_last[1]),
    .S1_AXIS_TUSER (s_user[1]),
    .S1_AXIS_TREADY(s_ready[1]),
    .M_AXIS_TDATA  (M_TDATA),
    .M_AXIS_TVALID (M_TVALID),
    .M_AXIS_TLAST  (M_TLAST),
    .M_AXIS_TUSER  (M_TUSER),
    .M_AXIS_TID    (M_TID),
    .M_AXIS_TREADY (M_TREADY),
    .R_AXIS_TVALID (r_valid),
    .R_AXIS_TREADY (r_ready),
    .GRANT         (GRANT),
    .OUTSTANDING   (OUTSTANDING)
  );

  always #5 ACLK = ~ACLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_pkt(input int n, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = TW'($urandom);
      b.last = (i == len - 1);
      b.user = 1'($urandom_range(0, 1));
      send_q[n].push_back(b);
    end
  endfunction

  // Requester model: AXI-compliant, holds a beat until accepted, optional bubbles.
  task automatic drive_loop(input int n);
    beat_t cur;
    bit    have = 0;
    forever begin
      @(posedge ACLK);
      #1;
      if (manual) begin
        have = 0;
        continue;
      end
      if (have && acc[n]) begin
        have       = 0;
        s_valid[n] = 1'b0;
      end
      if (!have && send_q[n].size() > 0 && $urandom_range(0, 99) >= bubble_pct) begin
        cur = send_q[n].pop_front();
        exp_q[n].push_back(cur);
        have       = 1;
        s_data[n]  = cur.data;
        s_last[n]  = cur.last;
        s_user[n]  = cur.user;
        s_valid[n] = 1'b1;
      end
    end
  endtask

  initial drive_loop(0);
  initial drive_loop(1);

  initial forever begin
    @(posedge ACLK);
    #1;
    if (m_auto) M_TREADY = ($urandom_range(0, 99) < m_pct);
    if (r_auto) begin
      r_valid = ($urandom_range(0, 99) < r_pct);
      r_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares observed bus behaviour against the packet-level reference.
  always @(negedge ACLK) begin
    int    gi, nxt, tmp;
    bit    mhs, inc, dec;
    beat_t b;
    if (!ARESETN) begin
      if (rst_prev) begin
        exp_q[0].delete();
        exp_q[1].delete();
      end
      out_m = 0; last_g = 1; grant_exp = 2'b00;
      in_pkt = 0; prev_stall = 0; acc[0] = 0; acc[1] = 0;
      rst_prev = 0;
    end else begin
      rst_prev = 1;
      chk("outstanding", 32'(OUTSTANDING), 32'(out_m));
      chk("grant", 32'(GRANT), 32'(grant_exp));
      gi = GRANT[1] ? 1 : 0;
      if (GRANT == 2'b00) begin
        chk("idle_tvalid", 32'(M_TVALID), 0);
        chk("idle_tready", {30'd0, s_ready[1], s_ready[0]}, 0);
      end else begin
        chk("tid", 32'(M_TID), gi);
        chk("pass_beat", {M_TVALID, M_TDATA, M_TLAST, M_TUSER},
            {s_valid[gi], s_data[gi], s_last[gi], s_user[gi]});
        chk("pass_tready", {30'd0, s_ready[1], s_ready[0]},
            gi == 1 ? {30'd0, M_TREADY, 1'b0} : {30'd0, 1'b0, M_TREADY});
      end
      if (prev_stall) chk("stall_stable", {6'd0, M_TDATA, M_TLAST, M_TUSER, M_TID}, prev_m);
      prev_stall = M_TVALID && !M_TREADY;
      prev_m     = {6'd0, M_TDATA, M_TLAST, M_TUSER, M_TID};

      mhs = M_TVALID && M_TREADY;
      if (mhs) begin
        if (exp_q[M_TID[0]].size() == 0) begin
          chk("unexpected_beat", {8'd0, M_TDATA, 8'd0}, 0);
        end else begin
          b = exp_q[M_TID[0]].pop_front();
          chk("beat", {14'd0, M_TDATA, M_TLAST, M_TUSER}, {14'd0, b.data, b.last, b.user});
        end
        if (!in_pkt) tid_log.push_back(M_TID);
        in_pkt = !M_TLAST;
      end
      acc[0] = s_valid[0] && s_ready[0];
      acc[1] = s_valid[1] && s_ready[1];

      inc = mhs && M_TLAST;
      dec = r_valid && r_ready;
      if (grant_exp == 2'b00) begin
        if (out_m < MAXO && (s_valid[0] || s_valid[1])) begin
          if (s_valid[0] && s_valid[1]) nxt = 1 - last_g;
          else nxt = s_valid[0] ? 0 : 1;
          grant_exp = (nxt == 0) ? 2'b01 : 2'b10;
        end
      end else if (inc) begin
        last_g    = grant_exp[1] ? 1 : 0;
        grant_exp = 2'b00;
      end
      tmp   = out_m + int'(inc) - int'(dec);
      out_m = (tmp < 0) ? 0 : tmp;
    end
  end

  task automatic wait_drain(input int bound);
    int c = 0;
    int pend;
    pend = send_q[0].size() + send_q[1].size() + exp_q[0].size() + exp_q[1].size();
    while (pend != 0 && c < bound) begin
      @(posedge ACLK);
      #1;
      c++;
      pend = send_q[0].size() + send_q[1].size() + exp_q[0].size() + exp_q[1].size();
    end
    chk("drain_pending", pend, 0);
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  task automatic r_pulse(input int k);
    r_valid = 1'b1;
    r_ready = 1'b1;
    repeat (k) @(posedge ACLK);
    #1;
    r_valid = 1'b0;
    r_ready = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g, input int bound);
    int c = 0;
    while (GRANT != g && c < bound) begin
      @(posedge ACLK);
      #1;
      c++;
    end
    chk("wait_grant", 32'(GRANT), 32'(g));
  endtask

  initial begin
    beat_t b;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 0; s_last[i] = 0; s_user[i] = 0;
    end
    M_TREADY = 1'b1; r_valid = 1'b0; r_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_outstanding", 32'(OUTSTANDING), 0);
    chk("rst_tvalid", 32'(M_TVALID), 0);
    chk("rst_tready", {30'd0, s_ready[1], s_ready[0]}, 0);
    ARESETN = 1'b1;

    // S0 alone, three beats
    tid_log.delete();
    b = '{data: 16'h0203, last: 1'b0, user: 1'b0}; send_q[0].push_back(b);
    b = '{data: 16'h0405, last: 1'b0, user: 1'b1}; send_q[0].push_back(b);
    b = '{data: 16'h0607, last: 1'b1, user: 1'b0}; send_q[0].push_back(b);
    wait_drain(200);
    chk("s0_outstanding", 32'(OUTSTANDING), 1);
    chk("s0_grant_idle", 32'(GRANT), 0);
    chk("s0_pkt_count", tid_log.size(), 1);
    if (tid_log.size() > 0) chk("s0_pkt_tid", 32'(tid_log[0]), 0);

    // Both valid from reset, 2-beat packets: round robin 0,1,0,1
    ARESETN = 1'b0;
    @(negedge ACLK);
    #1;
    tid_log.delete();
    push_pkt(0, 2); push_pkt(1, 2); push_pkt(0, 2); push_pkt(1, 2);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    wait_drain(200);
    chk("rr_pkt_count", tid_log.size(), 4);
    if (tid_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_tid", 32'(tid_log[i]), i % 2);
    end
    chk("rr_outstanding", 32'(OUTSTANDING), MAXO);

    // Full: S1 waits until one result returns
    push_pkt(1, 1);
    repeat (4) @(posedge ACLK);
    #1;
    chk("full_hold_grant", 32'(GRANT), 0);
    r_pulse(1);
    chk("full_after_r_out", 32'(OUTSTANDING), MAXO - 1);
    chk("full_after_r_grant", 32'(GRANT), 0);
    @(posedge ACLK);
    #1;
    chk("full_release_grant", 32'(GRANT), 2'b10);
    wait_drain(200);
    r_pulse(6);
    chk("drained_out", 32'(OUTSTANDING), 0);

    // Backpressure mid-packet while S1 is valid
    M_TREADY = 1'b0;
    push_pkt(0, 3);
    wait_grant(2'b01, 20);
    M_TREADY = 1'b1;
    @(posedge ACLK);
    #1;
    M_TREADY = 1'b0;
    push_pkt(1, 1);
    repeat (3) begin
      @(posedge ACLK);
      #1;
      chk("stall_grant", 32'(GRANT), 2'b01);
    end
    M_TREADY = 1'b1;
    wait_drain(200);
    r_pulse(6);

    // Randomized soak
    for (int k = 0; k < 150; k++) begin
      push_pkt(0, $urandom_range(1, 4));
      push_pkt(1, $urandom_range(1, 4));
    end
    bubble_pct = 25; m_pct = 75; r_pct = 30;
    m_auto = 1; r_auto = 1;
    wait_drain(20000);
    m_auto = 0; r_auto = 0; bubble_pct = 0;
    M_TREADY = 1'b1;
    r_pulse(16);
    chk("soak_out", 32'(OUTSTANDING), 0);

    // Reset during beat 2 of an S1 packet
    manual = 1;
    @(posedge ACLK);
    #1;
    b = '{data: 16'hA1B2, last: 1'b0, user: 1'b1};
    exp_q[1].push_back(b);
    s_data[1] = b.data; s_last[1] = b.last; s_user[1] = b.user; s_valid[1] = 1'b1;
    wait_grant(2'b10, 20);
    @(posedge ACLK);
    #1;
    b = '{data: 16'hC3D4, last: 1'b0, user: 1'b0};
    exp_q[1].push_back(b);
    s_data[1] = b.data; s_last[1] = b.last; s_user[1] = b.user;
    #2;
    ARESETN = 1'b0;
    #1;
    chk("arst_grant", 32'(GRANT), 0);
    chk("arst_tvalid", 32'(M_TVALID), 0);
    chk("arst_tready", {30'd0, s_ready[1], s_ready[0]}, 0);
    chk("arst_outstanding", 32'(OUTSTANDING), 0);
    @(negedge ACLK);
    #1;
    s_data[0] = 16'h1111; s_last[0] = 1'b1; s_user[0] = 1'b0; s_valid[0] = 1'b1;
    s_data[1] = 16'h2222; s_last[1] = 1'b1; s_user[1] = 1'b1; s_valid[1] = 1'b1;
    b = '{data: 16'h1111, last: 1'b1, user: 1'b0}; exp_q[0].push_back(b);
    b = '{data: 16'h2222, last: 1'b1, user: 1'b1}; exp_q[1].push_back(b);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    wait_grant(2'b01, 5);
    chk("tie_after_reset", 32'(GRANT), 2'b01);
    @(posedge ACLK);
    #1;
    s_valid[0] = 1'b0;
    wait_grant(2'b10, 5);
    @(posedge ACLK);
    #1;
    s_valid[1] = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("final_exp_empty", exp_q[0].size() + exp_q[1].size(), 0);
    chk("final_out", 32'(OUTSTANDING), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
